// File: rtl/ili9341_byte_feeder.sv
// Upstream feeder for the ILI9341 SPI byte engine: queues {dc,last,byte} entries, sequences
// display power-up reset timing, and drives chip select / D-C around each launched byte.
module ili9341_byte_feeder #(
   parameter int FIFO_AW     = 2,
   parameter int RST_CYCLES  = 500000,
   parameter int WAKE_CYCLES = 6000000,
   parameter int CNT_BITS    = 23,
   parameter int CS_GAP      = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   input  logic [7:0] in_data_i,
   input  logic       in_dc_i,
   input  logic       in_last_i,
   output logic       spi_go_o,
   output logic [7:0] spi_data_o,
   input  logic       spi_done_i,
   output logic       lcd_cs_n_o,
   output logic       lcd_dc_o,
   output logic       lcd_rst_n_o,
   output logic       init_done_o,
   output logic       busy_o
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int CW    = FIFO_AW + 1;
   localparam logic [CNT_BITS-1:0] RST_LAST  = CNT_BITS'(RST_CYCLES - 1);
   localparam logic [CNT_BITS-1:0] WAKE_LAST = CNT_BITS'(WAKE_CYCLES - 1);
   localparam logic [CNT_BITS-1:0] GAP_LAST  = CNT_BITS'(CS_GAP - 1);
   localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);

   typedef enum logic [2:0] {
      RST_HOLD,
      WAKE,
      IDLE,
      ARM,
      XFER,
      HOLD,
      GAP
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;

   logic [9:0]          mem_q [DEPTH];
   logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]       count_q;

   logic                spi_go_q, spi_go_d;
   logic [7:0]          spi_data_q, spi_data_d;
   logic                lcd_cs_n_q, lcd_cs_n_d;
   logic                lcd_dc_q, lcd_dc_d;
   logic                last_q, last_d;
   logic                init_done_q, init_done_d;

   logic                fifo_empty, fifo_full, push, launch;
   logic [7:0]          head_data;
   logic                head_dc, head_last;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CW'(DEPTH));
   assign push       = in_valid_i && !fifo_full;
   assign {head_dc, head_last, head_data} = mem_q[rd_ptr_q];

   // Storage is not reset; only the pointers and occupancy define what is valid.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {in_dc_i, in_last_i, in_data_i};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= RST_HOLD;
         cnt_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         spi_go_q    <= 1'b0;
         spi_data_q  <= 8'h00;
         lcd_cs_n_q  <= 1'b1;
         lcd_dc_q    <= 1'b0;
         last_q      <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (launch) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q     <= count_q + CW'(push) - CW'(launch);
         spi_go_q    <= spi_go_d;
         spi_data_q  <= spi_data_d;
         lcd_cs_n_q  <= lcd_cs_n_d;
         lcd_dc_q    <= lcd_dc_d;
         last_q      <= last_d;
         init_done_q <= init_done_d;
      end
   end

   // One counter serves the reset hold, the wake delay and the chip-select gap.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      launch  = 1'b0;
      unique case (state_q)
         RST_HOLD: begin
            if (cnt_q == RST_LAST) begin
               state_d = WAKE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         WAKE: begin
            if (cnt_q == WAKE_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         IDLE: begin
            if (!fifo_empty && spi_done_i) begin
               launch  = 1'b1;
               state_d = ARM;
            end
         end
         ARM: begin
            if (!spi_done_i) begin
               state_d = XFER;
            end
         end
         XFER: begin
            if (spi_done_i) begin
               if (last_q) begin
                  state_d = GAP;
                  cnt_d   = '0;
               end else if (!fifo_empty) begin
                  launch  = 1'b1;
                  state_d = ARM;
               end else begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (!fifo_empty) begin
               launch  = 1'b1;
               state_d = ARM;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = RST_HOLD;
            cnt_d   = '0;
         end
      endcase
   end

   // Byte and D/C only move on a launch, so they stay stable for the whole byte.
   always_comb begin
      spi_go_d    = launch;
      spi_data_d  = spi_data_q;
      lcd_dc_d    = lcd_dc_q;
      lcd_cs_n_d  = lcd_cs_n_q;
      last_d      = last_q;
      init_done_d = init_done_q;
      if (launch) begin
         spi_data_d = head_data;
         lcd_dc_d   = head_dc;
         lcd_cs_n_d = 1'b0;
         last_d     = head_last;
      end
      if (state_q == XFER && spi_done_i && last_q) begin
         lcd_cs_n_d = 1'b1;
      end
      if (state_q == WAKE && cnt_q == WAKE_LAST) begin
         init_done_d = 1'b1;
      end
   end

   assign in_ready_o  = !fifo_full;
   assign spi_go_o    = spi_go_q;
   assign spi_data_o  = spi_data_q;
   assign lcd_cs_n_o  = lcd_cs_n_q;
   assign lcd_dc_o    = lcd_dc_q;
   assign lcd_rst_n_o = (state_q != RST_HOLD);
   assign init_done_o = init_done_q;
   assign busy_o      = (state_q inside {ARM, XFER, HOLD, GAP}) || !fifo_empty;

endmodule

// File: tb/tb_ili9341_byte_feeder.sv
// Directed bench for ili9341_byte_feeder with short reset/wake timing and a simple
// byte-engine model that takes four cycles per byte.
module tb_ili9341_byte_feeder;

   logic       clk = 1'b0;
   logic       rst;
   logic       inValid;
   logic       inReady;
   logic [7:0] inData;
   logic       inDc;
   logic       inLast;
   logic       spiGo;
   logic [7:0] spiData;
   logic       spiDone;
   logic       lcdCsN;
   logic       lcdDc;
   logic       lcdRstN;
   logic       initDone;
   logic       busy;

   int         assertCount = 0;
   int         failCount   = 0;

   int         engCnt      = 0;
   int         goCount     = 0;
   int         csFalls     = 0;
   logic       prevCs      = 1'b1;
   int         capCount    = 0;
   logic [7:0] capData [64];
   logic       capDc   [64];
   logic       capCs   [64];

   ili9341_byte_feeder #(
      .FIFO_AW    (2),
      .RST_CYCLES (4),
      .WAKE_CYCLES(8),
      .CNT_BITS   (23),
      .CS_GAP     (2)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .in_valid_i (inValid),
      .in_ready_o (inReady),
      .in_data_i  (inData),
      .in_dc_i    (inDc),
      .in_last_i  (inLast),
      .spi_go_o   (spiGo),
      .spi_data_o (spiData),
      .spi_done_i (spiDone),
      .lcd_cs_n_o (lcdCsN),
      .lcd_dc_o   (lcdDc),
      .lcd_rst_n_o(lcdRstN),
      .init_done_o(initDone),
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   // Byte engine: done drops the cycle after go, rises again four cycles after go.
   // Also records every launched byte with the D/C and CS seen at launch.
   always @(posedge clk) begin
      prevCs <= lcdCsN;
      if (prevCs === 1'b1 && lcdCsN === 1'b0) begin
         csFalls <= csFalls + 1;
      end
      if (spiGo === 1'b1) begin
         goCount           <= goCount + 1;
         capData[capCount] <= spiData;
         capDc[capCount]   <= lcdDc;
         capCs[capCount]   <= lcdCsN;
         capCount          <= capCount + 1;
      end
      if (rst) begin
         spiDone <= 1'b1;
         engCnt  <= 0;
      end else if (spiGo && spiDone) begin
         spiDone <= 1'b0;
         engCnt  <= 3;
      end else if (engCnt != 0) begin
         engCnt <= engCnt - 1;
         if (engCnt == 1) begin
            spiDone <= 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic dc,
                                input logic last);
      inValid = valid;
      inData  = data;
      inDc    = dc;
      inLast  = last;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic waitIdle(input string tag, input int budget);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin
         tick();
         n++;
      end
      checkOutput(tag, busy, 1'b0);
   endtask

   // Compares captured bytes starting at base against expected byte/dc lists.
   task automatic checkCaptures(input string tag, input int base, input int num,
                                input logic [7:0] expData [8], input logic expDc [8]);
      checkOutput($sformatf("%sCount", tag), capCount - base, num);
      for (int i = 0; i < num; i++) begin
         checkOutput($sformatf("%sByte%0d", tag, i), capData[base + i], expData[i]);
         checkOutput($sformatf("%sDc%0d", tag, i), capDc[base + i], expDc[i]);
         checkOutput($sformatf("%sCs%0d", tag, i), capCs[base + i], 1'b0);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      int               capBase;
      int               fallBase;
      int               goBase;
      int               n;
      int               k;
      logic             accepted;
      logic [7:0]       expData [8];
      logic             expDc   [8];

      // Reset and power-up timing
      rst = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      checkOutput("rstSpiGo", spiGo, 1'b0);
      checkOutput("rstSpiData", spiData, 8'h00);
      checkOutput("rstCsN", lcdCsN, 1'b1);
      checkOutput("rstDc", lcdDc, 1'b0);
      checkOutput("rstLcdRstN", lcdRstN, 1'b0);
      checkOutput("rstInitDone", initDone, 1'b0);
      checkOutput("rstBusy", busy, 1'b0);
      checkOutput("rstInReady", inReady, 1'b1);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("holdRstN%0d", i), lcdRstN, 1'b0);
      end
      tick();
      checkOutput("rstNReleased", lcdRstN, 1'b1);
      for (int i = 0; i < 7; i++) begin
         tick();
         checkOutput($sformatf("wakeInit%0d", i), initDone, 1'b0);
         checkOutput($sformatf("wakeCs%0d", i), lcdCsN, 1'b1);
      end
      tick();
      checkOutput("initDoneRise", initDone, 1'b1);

      // Three-byte transaction: command 0x2A, then two parameters
      capBase  = capCount;
      fallBase = csFalls;
      applyStimulus(1'b1, 8'h2A, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
      tick();
      checkOutput("t2LaunchGo", spiGo, 1'b1);
      checkOutput("t2LaunchData", spiData, 8'h2A);
      checkOutput("t2LaunchDc", lcdDc, 1'b0);
      checkOutput("t2LaunchCs", lcdCsN, 1'b0);
      applyStimulus(1'b1, 8'hEF, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      n = 1;
      while (lcdCsN === 1'b0 && n < 60) begin
         tick();
         n++;
      end
      checkOutput("t2CsRiseCycle", n, 15);
      checkOutput("t2GapBusy0", busy, 1'b1);
      tick();
      checkOutput("t2GapCs1", lcdCsN, 1'b1);
      checkOutput("t2GapBusy1", busy, 1'b1);
      tick();
      checkOutput("t2GapEnd", busy, 1'b0);
      checkOutput("t2CsStillHigh", lcdCsN, 1'b1);
      expData = '{8'h2A, 8'h00, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      expDc   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      checkCaptures("t2", capBase, 3, expData, expDc);
      checkOutput("t2CsFalls", csFalls - fallBase, 1);

      // Six entries back-to-back: FIFO fills, producer stalls, nothing lost
      capBase  = capCount;
      fallBase = csFalls;
      k = 0;
      n = 0;
      while (k < 6 && n < 100) begin
         applyStimulus(1'b1, 8'(8'h10 + k), 1'b1, (k == 5));
         accepted = inReady;
         tick();
         n++;
         if (accepted) k++;
         if (n == 5) begin
            checkOutput("t3FullReady", inReady, 1'b0);
            checkOutput("t3AcceptedAtFull", k, 5);
         end
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t3AllAccepted", k, 6);
      waitIdle("t3Idle", 200);
      expData = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h00, 8'h00};
      expDc   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      checkCaptures("t3", capBase, 6, expData, expDc);
      checkOutput("t3CsFalls", csFalls - fallBase, 1);
      checkOutput("t3CsHigh", lcdCsN, 1'b1);

      // Entries pushed during reset hold are kept until init completes
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("t4RstN", lcdRstN, 1'b0);
      capBase = capCount;
      goBase  = goCount;
      applyStimulus(1'b1, 8'h36, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 8'h48, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t4BusyHeld", busy, 1'b1);
      n = 0;
      while (initDone !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      checkOutput("t4InitDone", initDone, 1'b1);
      checkOutput("t4NoEarlyGo", goCount - goBase, 0);
      checkOutput("t4GoLowAtInit", spiGo, 1'b0);
      tick();
      checkOutput("t4FirstGo", spiGo, 1'b1);
      checkOutput("t4FirstData", spiData, 8'h36);
      waitIdle("t4Idle", 100);
      expData = '{8'h36, 8'h48, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      expDc   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      checkCaptures("t4", capBase, 2, expData, expDc);

      // Non-last byte with a stalled producer keeps chip select low
      capBase  = capCount;
      fallBase = csFalls;
      applyStimulus(1'b1, 8'h2C, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      repeat (20) tick();
      checkOutput("t5HoldCs", lcdCsN, 1'b0);
      checkOutput("t5HoldBusy", busy, 1'b1);
      checkOutput("t5HoldGo", spiGo, 1'b0);
      checkOutput("t5HoldCount", capCount - capBase, 1);
      applyStimulus(1'b1, 8'h55, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      checkOutput("t5ResumeGo", spiGo, 1'b1);
      checkOutput("t5ResumeData", spiData, 8'h55);
      checkOutput("t5ResumeDc", lcdDc, 1'b1);
      checkOutput("t5ResumeCs", lcdCsN, 1'b0);
      waitIdle("t5Idle", 100);
      expData = '{8'h2C, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      expDc   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      checkCaptures("t5", capBase, 2, expData, expDc);
      checkOutput("t5CsFalls", csFalls - fallBase, 1);

      // Reset in the middle of a byte transfer
      applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 8'h22, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      n = 0;
      while (spiDone !== 1'b0 && n < 10) begin
         tick();
         n++;
      end
      checkOutput("t6EngineBusy", spiDone, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      checkOutput("t6CsN", lcdCsN, 1'b1);
      checkOutput("t6Go", spiGo, 1'b0);
      checkOutput("t6RstN", lcdRstN, 1'b0);
      checkOutput("t6Busy", busy, 1'b0);
      checkOutput("t6InitDone", initDone, 1'b0);
      checkOutput("t6InReady", inReady, 1'b1);
      rst = 1'b0;
      tick();
      checkOutput("t6FifoFlushed", busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
